fighter_health: RTL and testbench
=================================

Name: fighter_health

Overview:
- Parametrised per-fighter health tracker and health-bar geometry generator for the VGA fight screen.
- Takes one-frame hit strobes from the collision/attack logic and applies weighted damage (punch vs kick).
- Enforces an invulnerability window after each hit, declares KO and handles the rematch key.
- Drives red (remaining) / green (lost) bar rectangles to the sprite/colour mapper. One instance per player.

Parameters:
- MAX_HP, 23, full health value; must be ≥1.
- HPW, 5, width of hp; must satisfy 2^HPW > MAX_HP.
- PUNCH_DMG, 1, HP removed by a punch hit.
- KICK_DMG, 2, HP removed by a kick hit.
- IFRAMES, 8, frames of invulnerability after a non-fatal hit; 0 disables the window.
- BAR_X, 50, bar left x (pixels).
- BAR_Y, 50, bar top y.
- BAR_W, 140, full bar width.
- BAR_H, 10, bar height.
- RESTART_KEY, 8'h15, keycode that restarts after KO.
- REGEN_PERIOD, 120, frames per regen step (used only with the optional feature).

Ports:
- frame_clk  in  1  frame-rate clock
- Reset  in  1  reset
- active  in  1  1 = round in play; 0 = hits ignored and all timers frozen
- hit_valid  in  1  one-frame hit strobe
- hit_kind  in  1  0 = punch, 1 = kick
- keycode  in  8  current keyboard code
- hp  out  HPW  current health
- lose  out  1  high while KO
- invuln  out  1  high during the invulnerability window
- redposx, greenposx, barposy, redsizex, greensizex, barsizey  out  10 each  bar geometry

Behaviour:
- Interface: reset Reset, asynchronous, active-high; clock frame_clk.
- Reset values:
  - State ALIVE, hp=MAX_HP, iframe counter 0, lose=0, invuln=0.
  - redposx=BAR_X, redsizex=BAR_W, greensizex=0, greenposx=BAR_X+BAR_W, barposy=BAR_Y, barsizey=BAR_H.
- States:
  - ALIVE:
    - On hit_valid&&active: dmg = hit_kind ? KICK_DMG : PUNCH_DMG, and hp <= (dmg>=hp) ? 0 : hp-dmg (saturating, no wrap).
    - If the new hp is 0, go to KO.
    - Otherwise, if IFRAMES>0, go to IFRAME with counter=IFRAMES; if IFRAMES==0, stay in ALIVE.
  - IFRAME:
    - invuln=1; all hits are ignored.
    - Counter decrements each frame while active; when it reaches 0, go to ALIVE.
    - A hit in the same frame the counter reaches 0 is ignored.
  - KO:
    - lose=1; hits are ignored; hp holds at 0.
    - keycode==RESTART_KEY goes to ALIVE with hp=MAX_HP. This does not depend on active.
    - Restart wins over a simultaneous hit.
- lose and invuln are decoded from the registered state, so they are valid the frame after the transition.
- Geometry:
  - rsx = (hp*BAR_W)/MAX_HP, floor, computed at 10+HPW bits.
  - gsx = BAR_W - rsx; greenposx = BAR_X + rsx.
  - Registered, so geometry lags hp by exactly one frame.
  - redposx, barposy and barsizey are constant after reset.
- Reset mid-operation (including mid-IFRAME) immediately restores all reset values.

Optional Feature:
- HEALTH_REGEN_EN defined:
  - A regen timer counts active frames in ALIVE while 0<hp<MAX_HP.
  - When it reaches REGEN_PERIOD, hp increments by 1 (capped at MAX_HP) and the timer clears.
  - Any accepted hit, entry to IFRAME/KO, or Reset clears the timer.
  - No regen in KO.
- HEALTH_REGEN_EN undefined: no timer logic; hp only decreases until restart.

Decomposition:
- health_pkg contains:
  - state enum {ALIVE, IFRAME, KO}.
  - HIT_PUNCH/HIT_KICK constants.
  - GEOM_W=10.
- Sub-module health_bar_geom: combinational hp→rsx/gsx/greenposx, parameterised by MAX_HP, HPW, BAR_X, BAR_W. The registers stay in fighter_health.

Test Plan:
- Reset asserted → hp=23, lose=0, invuln=0, redsizex=140, greensizex=0, greenposx=190, barposy=50, barsizey=10.
- Punch at frame N →
  - hp=22 at N+1.
  - invuln=1 frames N+1..N+8.
  - At N+2: redsizex=133, greensizex=7, greenposx=183.
- Punch at N+3 (during IFRAME) → ignored, hp stays 22; the same hit at N+10 → hp=21.
- hp=1, kick → hp=0, lose=1 next frame, then redsizex=0, greensizex=140, greenposx=50; further hits leave hp=0.
- In KO, keycode=8'h15 with simultaneous hit_valid → hp=23, lose=0, invuln=0; with active=0, a hit does not change hp.
- Reset pulse mid-IFRAME → hp=23, invuln=0 immediately.
- HEALTH_REGEN_EN build: hp=20 with 120 hit-free active frames → hp=21; a hit at frame 119 → no regen.

Source files
------------

// File: rtl/health_pkg.sv
// Shared types and constants for the per-fighter health tracker.
// Contents: FSM state enum, hit-kind encodings, geometry bus width.
// No ports; imported by fighter_health and health_bar_geom.
package health_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        IFRAME = 2'd1,
        KO     = 2'd2
    } state_t;

    localparam logic HIT_PUNCH = 1'b0;
    localparam logic HIT_KICK  = 1'b1;

    localparam int GEOM_W = 10;

endpackage

// File: rtl/health_bar_geom.sv
// Combinational health-bar geometry: maps hp to red/green widths and green x.
// Ports: hp in; rsx = floor(hp*BAR_W/MAX_HP), gsx = BAR_W-rsx, greenposx = BAR_X+rsx.
// No registers; the parent registers the outputs.
module health_bar_geom
    import health_pkg::*;
#(
    parameter int MAX_HP = 23,
    parameter int HPW    = 5,
    parameter int BAR_X  = 50,
    parameter int BAR_W  = 140
) (
    input  logic [HPW-1:0]    hp,
    output logic [GEOM_W-1:0] rsx,
    output logic [GEOM_W-1:0] gsx,
    output logic [GEOM_W-1:0] greenposx
);

    localparam int PW = GEOM_W + HPW;

    logic [PW-1:0] prod;
    logic [PW-1:0] quo;

    // Product is widened before the multiply so hp*BAR_W cannot overflow.
    assign prod      = PW'(hp) * PW'(BAR_W);
    assign quo       = prod / PW'(MAX_HP);
    assign rsx       = quo[GEOM_W-1:0];
    assign gsx       = GEOM_W'(BAR_W) - rsx;
    assign greenposx = GEOM_W'(BAR_X) + rsx;

endmodule

// File: rtl/fighter_health.sv
// Per-fighter health tracker: weighted damage, invulnerability window, KO and
// rematch key, plus registered health-bar geometry (lags hp by one frame).
// Ports: frame_clk/Reset (async, active-high); active, hit_valid, hit_kind, keycode in;
//        hp, lose, invuln and six 10-bit bar geometry outputs.
// Optional: define HEALTH_REGEN_EN for slow hp regeneration while alive.
module fighter_health
    import health_pkg::*;
#(
    parameter int         MAX_HP       = 23,
    parameter int         HPW          = 5,
    parameter int         PUNCH_DMG    = 1,
    parameter int         KICK_DMG     = 2,
    parameter int         IFRAMES      = 8,
    parameter int         BAR_X        = 50,
    parameter int         BAR_Y        = 50,
    parameter int         BAR_W        = 140,
    parameter int         BAR_H        = 10,
    parameter logic [7:0] RESTART_KEY  = 8'h15,
    parameter int         REGEN_PERIOD = 120
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              active,
    input  logic              hit_valid,
    input  logic              hit_kind,
    input  logic [7:0]        keycode,
    output logic [HPW-1:0]    hp,
    output logic              lose,
    output logic              invuln,
    output logic [GEOM_W-1:0] redposx,
    output logic [GEOM_W-1:0] greenposx,
    output logic [GEOM_W-1:0] barposy,
    output logic [GEOM_W-1:0] redsizex,
    output logic [GEOM_W-1:0] greensizex,
    output logic [GEOM_W-1:0] barsizey
);

    // Elaboration-time parameter sanity.
    if (MAX_HP < 1 || (1 << HPW) <= MAX_HP || REGEN_PERIOD < 1) begin : g_bad_param
        $error("fighter_health: illegal MAX_HP/HPW/REGEN_PERIOD");
    end

    localparam int CW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
    localparam logic [HPW-1:0] PUNCH_HP = HPW'(PUNCH_DMG);
    localparam logic [HPW-1:0] KICK_HP  = HPW'(KICK_DMG);

    state_t          state;
    logic [CW-1:0]   iframe_cnt;
    logic [HPW-1:0]  dmg;
    logic [HPW-1:0]  hp_after;
    logic            hit_taken;
    logic [GEOM_W-1:0] rsx_next;
    logic [GEOM_W-1:0] gsx_next;
    logic [GEOM_W-1:0] gpx_next;

`ifdef HEALTH_REGEN_EN
    localparam int RW = $clog2(REGEN_PERIOD + 1);
    logic [RW-1:0] regen_cnt;
`endif

    // Saturating damage: a hit never wraps hp below zero.
    assign dmg       = (hit_kind == HIT_KICK) ? KICK_HP : PUNCH_HP;
    assign hp_after  = (dmg >= hp) ? '0 : hp - dmg;
    assign hit_taken = hit_valid && active;

    assign lose   = (state == KO);
    assign invuln = (state == IFRAME);

    assign redposx  = GEOM_W'(BAR_X);
    assign barposy  = GEOM_W'(BAR_Y);
    assign barsizey = GEOM_W'(BAR_H);

    health_bar_geom #(
        .MAX_HP (MAX_HP),
        .HPW    (HPW),
        .BAR_X  (BAR_X),
        .BAR_W  (BAR_W)
    ) u_geom (
        .hp        (hp),
        .rsx       (rsx_next),
        .gsx       (gsx_next),
        .greenposx (gpx_next)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= ALIVE;
            hp         <= HPW'(MAX_HP);
            iframe_cnt <= '0;
            redsizex   <= GEOM_W'(BAR_W);
            greensizex <= '0;
            greenposx  <= GEOM_W'(BAR_X + BAR_W);
`ifdef HEALTH_REGEN_EN
            regen_cnt  <= '0;
`endif
        end else begin
            redsizex   <= rsx_next;
            greensizex <= gsx_next;
            greenposx  <= gpx_next;

            case (state)
                ALIVE: begin
                    if (hit_taken) begin
                        hp <= hp_after;
`ifdef HEALTH_REGEN_EN
                        regen_cnt <= '0;
`endif
                        if (hp_after == '0) begin
                            state <= KO;
                        end else if (IFRAMES > 0) begin
                            state      <= IFRAME;
                            iframe_cnt <= CW'(IFRAMES);
                        end
                    end
`ifdef HEALTH_REGEN_EN
                    else if (active && hp != '0 && hp < HPW'(MAX_HP)) begin
                        if (regen_cnt == RW'(REGEN_PERIOD - 1)) begin
                            hp        <= hp + 1'b1;
                            regen_cnt <= '0;
                        end else begin
                            regen_cnt <= regen_cnt + 1'b1;
                        end
                    end
`endif
                end
                IFRAME: begin
                    // Timer freezes while the round is paused; hits ignored throughout.
                    if (active) begin
                        if (iframe_cnt <= CW'(1)) begin
                            iframe_cnt <= '0;
                            state      <= ALIVE;
                        end else begin
                            iframe_cnt <= iframe_cnt - 1'b1;
                        end
                    end
                end
                KO: begin
                    // Rematch is independent of active and overrides any hit.
                    if (keycode == RESTART_KEY) begin
                        state <= ALIVE;
                        hp    <= HPW'(MAX_HP);
                    end
                end
                default: state <= ALIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_fighter_health.sv
module tb_fighter_health;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       active;
    logic       hit_valid;
    logic       hit_kind;
    logic [7:0] keycode;
    logic [4:0] hp;
    logic       lose;
    logic       invuln;
    logic [9:0] redposx, greenposx, barposy, redsizex, greensizex, barsizey;

    fighter_health dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .active     (active),
        .hit_valid  (hit_valid),
        .hit_kind   (hit_kind),
        .keycode    (keycode),
        .hp         (hp),
        .lose       (lose),
        .invuln     (invuln),
        .redposx    (redposx),
        .greenposx  (greenposx),
        .barposy    (barposy),
        .redsizex   (redsizex),
        .greensizex (greensizex),
        .barsizey   (barsizey)
    );

    always #5 frame_clk = ~frame_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         rep;
        logic       act;
        logic       hit;
        logic       kind;
        logic [7:0] key;
        int         ehp;
        logic       elose;
        logic       einv;
        int         ersx;   // -1: geometry not checked for this record
        int         egsx;
        int         egpx;
        string      name;
    } vec_t;

    typedef struct {
        int    ehp;
        logic  elose;
        logic  einv;
        string name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_geom(input string name, input int rsx, input int gsx, input int gpx);
        chk({name, "_redsizex"},   int'(redsizex),   rsx);
        chk({name, "_greensizex"}, int'(greensizex), gsx);
        chk({name, "_greenposx"},  int'(greenposx),  gpx);
    endtask

    // Drive one frame of inputs, queue the expected post-edge state, then
    // compare once the DUT has clocked it in.
    task automatic step(input logic a, input logic h, input logic k, input logic [7:0] key,
                        input int ehp, input logic el, input logic ei, input string nm);
        exp_t e;
        active    = a;
        hit_valid = h;
        hit_kind  = k;
        keycode   = key;
        sb.push_back('{ehp, el, ei, nm});
        @(posedge frame_clk);
        @(negedge frame_clk);
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_hp"},     int'(hp),     e.ehp);
            chk({e.name, "_lose"},   int'(lose),   int'(e.elose));
            chk({e.name, "_invuln"}, int'(invuln), int'(e.einv));
        end
    endtask

    function automatic vec_t mkv(input int rep, input logic a, input logic h, input logic k,
                                 input logic [7:0] key, input int ehp, input logic el,
                                 input logic ei, input int rsx, input int gsx, input int gpx,
                                 input string nm);
        vec_t v;
        v.rep = rep; v.act = a; v.hit = h; v.kind = k; v.key = key;
        v.ehp = ehp; v.elose = el; v.einv = ei;
        v.ersx = rsx; v.egsx = gsx; v.egpx = gpx; v.name = nm;
        return v;
    endfunction

    initial begin
        int cur_hp;
        Reset     = 1'b1;
        active    = 1'b0;
        hit_valid = 1'b0;
        hit_kind  = 1'b0;
        keycode   = 8'h00;

        // Frame N is the first table record. Expectations are post-edge.
        tbl.push_back(mkv(1, 1, 1, 0, 8'h00, 22, 0, 1, -1, -1, -1, "punch_n"));
        tbl.push_back(mkv(1, 1, 0, 0, 8'h00, 22, 0, 1, 133, 7, 183, "geom_n2"));
        tbl.push_back(mkv(1, 1, 0, 0, 8'h00, 22, 0, 1, -1, -1, -1, "idle_n2"));
        tbl.push_back(mkv(1, 1, 1, 0, 8'h00, 22, 0, 1, -1, -1, -1, "punch_in_iframe"));
        tbl.push_back(mkv(4, 1, 0, 0, 8'h00, 22, 0, 1, 133, 7, 183, "iframe_hold"));
        tbl.push_back(mkv(1, 1, 1, 1, 8'h00, 22, 0, 0, -1, -1, -1, "hit_at_iframe_end"));
        tbl.push_back(mkv(1, 1, 0, 0, 8'h00, 22, 0, 0, -1, -1, -1, "alive_n9"));
        tbl.push_back(mkv(1, 1, 1, 0, 8'h00, 21, 0, 1, -1, -1, -1, "punch_n10"));
        tbl.push_back(mkv(20, 0, 1, 1, 8'h00, 21, 0, 1, -1, -1, -1, "frozen_iframe"));
        tbl.push_back(mkv(7, 1, 0, 0, 8'h00, 21, 0, 1, -1, -1, -1, "resume_iframe"));
        tbl.push_back(mkv(1, 1, 0, 0, 8'h00, 21, 0, 0, 127, 13, 177, "iframe_done"));
        tbl.push_back(mkv(2, 0, 1, 1, 8'h00, 21, 0, 0, -1, -1, -1, "inactive_hit"));

        @(negedge frame_clk);
        chk("rst_hp", int'(hp), 23);
        chk("rst_lose", int'(lose), 0);
        chk("rst_invuln", int'(invuln), 0);
        chk_geom("rst", 140, 0, 190);
        chk("rst_redposx", int'(redposx), 50);
        chk("rst_barposy", int'(barposy), 50);
        chk("rst_barsizey", int'(barsizey), 10);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step(tbl[i].act, tbl[i].hit, tbl[i].kind, tbl[i].key,
                     tbl[i].ehp, tbl[i].elose, tbl[i].einv, tbl[i].name);
                if (tbl[i].ersx >= 0)
                    chk_geom(tbl[i].name, tbl[i].ersx, tbl[i].egsx, tbl[i].egpx);
            end
        end

        // Kick down from 21 to 1, checking geometry one frame after each hit.
        cur_hp = 21;
        for (int k = 0; k < 10; k++) begin
            cur_hp = cur_hp - 2;
            step(1, 1, 1, 8'h00, cur_hp, 0, 1, "kick_down");
            step(1, 0, 0, 8'h00, cur_hp, 0, 1, "kick_idle");
            chk_geom("kick_geom", (cur_hp * 140) / 23, 140 - (cur_hp * 140) / 23,
                     50 + (cur_hp * 140) / 23);
            for (int j = 0; j < 6; j++) step(1, 0, 0, 8'h00, cur_hp, 0, 1, "kick_iframe");
            step(1, 0, 0, 8'h00, cur_hp, 0, 0, "kick_exit");
        end

        // Fatal kick at hp=1 saturates to 0.
        step(1, 1, 1, 8'h00, 0, 1, 0, "fatal_kick");
        step(1, 0, 0, 8'h00, 0, 1, 0, "ko_idle");
        chk_geom("ko", 0, 140, 50);
        for (int j = 0; j < 3; j++) step(1, 1, 1, 8'h00, 0, 1, 0, "ko_hit");
        step(1, 1, 0, 8'h14, 0, 1, 0, "ko_wrong_key");
        step(0, 1, 1, 8'h00, 0, 1, 0, "ko_inactive_hit");
        step(1, 1, 1, 8'h15, 23, 0, 0, "restart_with_hit");
        step(1, 0, 0, 8'h00, 23, 0, 0, "after_restart");
        step(0, 1, 1, 8'h00, 23, 0, 0, "inactive_hit_full");

        // Reset pulse in the middle of an invulnerability window.
        step(1, 1, 0, 8'h00, 22, 0, 1, "pre_reset_punch");
        step(1, 0, 0, 8'h00, 22, 0, 1, "pre_reset_iframe");
        Reset = 1'b1;
        #1;
        chk("midrst_hp", int'(hp), 23);
        chk("midrst_invuln", int'(invuln), 0);
        chk("midrst_lose", int'(lose), 0);
        chk_geom("midrst", 140, 0, 190);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(1, 0, 0, 8'h00, 23, 0, 0, "post_reset");

`ifdef HEALTH_REGEN_EN
        step(1, 1, 1, 8'h00, 21, 0, 1, "regen_kick");
        for (int j = 0; j < 7; j++) step(1, 0, 0, 8'h00, 21, 0, 1, "regen_if1");
        step(1, 0, 0, 8'h00, 21, 0, 0, "regen_if1_exit");
        step(1, 1, 0, 8'h00, 20, 0, 1, "regen_punch");
        for (int j = 0; j < 7; j++) step(1, 0, 0, 8'h00, 20, 0, 1, "regen_if2");
        step(1, 0, 0, 8'h00, 20, 0, 0, "regen_if2_exit");
        for (int j = 0; j < 119; j++) step(1, 0, 0, 8'h00, 20, 0, 0, "regen_wait");
        step(1, 0, 0, 8'h00, 21, 0, 0, "regen_step");
        for (int j = 0; j < 118; j++) step(1, 0, 0, 8'h00, 21, 0, 0, "regen_wait2");
        step(1, 1, 0, 8'h00, 20, 0, 1, "regen_hit_119");
`endif

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
